// File: rtl/pixel_array_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pixel_array_readout
// Brief    : Erase / expose / row-by-row ramp-compare sequencer for a
//            ROWS x COLS pixel array, one row per ready/valid beat.
//            Optional macro DIGITAL_CDS_EN: reset + signal sample per row.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_array_readout #(
    parameter int ROWS         = 2,
    parameter int COLS         = 2,
    parameter int ADC_BITS     = 8,
    parameter int ERASE_CYCLES = 5
) (
    input  logic                                       Clk,
    input  logic                                       Reset,
    input  logic                                       Init,
    input  logic [15:0]                                Expose_time,
    input  logic [COLS-1:0]                            Comp,
    output logic                                       Erase,
    output logic                                       Expose,
    output logic [ROWS-1:0]                            NRE,
    output logic                                       ADC,
    output logic [COLS*ADC_BITS-1:0]                   Data,
    output logic                                       Data_valid,
    input  logic                                       Data_ready,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] Row_idx,
    output logic                                       Busy,
    output logic                                       Frame_done
);

    localparam int                  c_ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADC_BITS-1:0] c_RAMP_MAX   = {ADC_BITS{1'b1}};
    localparam logic [15:0]         c_ERASE_LAST = 16'(ERASE_CYCLES - 1);
    localparam logic [c_ROW_W-1:0]  c_LAST_ROW   = c_ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_OUTPUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                        r_state;
    logic [15:0]                   r_cnt;
    logic [15:0]                   r_exp_len;
    logic [ADC_BITS-1:0]           r_ramp;
    logic [c_ROW_W-1:0]            r_row;
    logic [COLS-1:0]               r_col_hit;
    logic [COLS-1:0][ADC_BITS-1:0] r_col_val;
    logic [COLS-1:0][ADC_BITS-1:0] w_col_final;
    logic [COLS*ADC_BITS-1:0]      w_row_data;
    logic                          w_ramp_last;
    logic                          w_sampling;

`ifdef DIGITAL_CDS_EN
    localparam logic [1:0] c_PH_RST = 2'd0;
    localparam logic [1:0] c_PH_GAP = 2'd1;
    localparam logic [1:0] c_PH_SIG = 2'd2;

    logic [1:0]                    r_cds_phase;
    logic [COLS-1:0][ADC_BITS-1:0] r_rst_val;
`endif

    // Active-low one-hot row enable for the given row.
    function automatic logic [ROWS-1:0] nre_for(input logic [c_ROW_W-1:0] row);
        logic [ROWS-1:0] v;
        v = '1;
        for (int i = 0; i < ROWS; i++) begin
            v[i] = (row != c_ROW_W'(i));
        end
        return v;
    endfunction

    always_comb begin
        w_ramp_last = (r_ramp == c_RAMP_MAX);
`ifdef DIGITAL_CDS_EN
        w_sampling  = (r_state == S_CONVERT) && (r_cds_phase != c_PH_GAP);
`else
        w_sampling  = (r_state == S_CONVERT);
`endif
        w_row_data  = '0;
        for (int c = 0; c < COLS; c++) begin
            // A column that never tripped saturates at full scale.
            w_col_final[c] = r_col_hit[c] ? r_col_val[c] : c_RAMP_MAX;
`ifdef DIGITAL_CDS_EN
            w_row_data[c*ADC_BITS +: ADC_BITS] = (w_col_final[c] > r_rst_val[c]) ?
                                                 (w_col_final[c] - r_rst_val[c]) : '0;
`else
            w_row_data[c*ADC_BITS +: ADC_BITS] = w_col_final[c];
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_exp_len   <= '0;
            r_ramp      <= '0;
            r_row       <= '0;
            r_col_hit   <= '0;
            r_col_val   <= '0;
            Erase       <= 1'b0;
            Expose      <= 1'b0;
            NRE         <= '1;
            ADC         <= 1'b0;
            Data        <= '0;
            Data_valid  <= 1'b0;
            Row_idx     <= '0;
            Busy        <= 1'b0;
            Frame_done  <= 1'b0;
`ifdef DIGITAL_CDS_EN
            r_cds_phase <= c_PH_RST;
            r_rst_val   <= '0;
`endif
        end else begin
            Frame_done <= 1'b0;

            // First comparator edge per ramp wins; later toggles are ignored.
            if (w_sampling) begin
                for (int c = 0; c < COLS; c++) begin
                    if (Comp[c] && !r_col_hit[c]) begin
                        r_col_hit[c] <= 1'b1;
                        r_col_val[c] <= r_ramp;
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (Init) begin
                        r_state   <= S_ERASE;
                        Busy      <= 1'b1;
                        Erase     <= 1'b1;
                        r_cnt     <= '0;
                        r_exp_len <= (Expose_time == 16'd0) ? 16'd1 : Expose_time;
                    end
                end

                S_ERASE: begin
                    if (r_cnt == c_ERASE_LAST) begin
                        r_state <= S_EXPOSE;
                        Erase   <= 1'b0;
                        Expose  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_EXPOSE: begin
                    if (r_cnt == r_exp_len - 16'd1) begin
                        r_state     <= S_CONVERT;
                        Expose      <= 1'b0;
                        r_row       <= '0;
                        NRE         <= nre_for('0);
                        ADC         <= 1'b1;
                        r_ramp      <= '0;
`ifdef DIGITAL_CDS_EN
                        Erase       <= 1'b1;
                        r_cds_phase <= c_PH_RST;
`endif
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_CONVERT: begin
`ifdef DIGITAL_CDS_EN
                    if (r_cds_phase == c_PH_GAP) begin
                        ADC         <= 1'b1;
                        r_ramp      <= '0;
                        r_cds_phase <= c_PH_SIG;
                    end else
`endif
                    if (!w_ramp_last) begin
                        r_ramp <= r_ramp + 1'b1;
                    end
`ifdef DIGITAL_CDS_EN
                    else if (r_cds_phase == c_PH_RST) begin
                        // Park the reset level; one idle cycle before the signal ramp.
                        r_rst_val   <= w_col_final;
                        r_col_hit   <= '0;
                        ADC         <= 1'b0;
                        Erase       <= 1'b0;
                        r_cds_phase <= c_PH_GAP;
                    end
`endif
                    else begin
                        r_state    <= S_OUTPUT;
                        ADC        <= 1'b0;
                        NRE        <= '1;
                        Data       <= w_row_data;
                        Data_valid <= 1'b1;
                        Row_idx    <= r_row;
                        r_col_hit  <= '0;
                    end
                end

                S_OUTPUT: begin
                    if (Data_ready) begin
                        Data_valid <= 1'b0;
                        if (r_row == c_LAST_ROW) begin
                            r_state    <= S_DONE;
                            Frame_done <= 1'b1;
                        end else begin
                            r_state     <= S_CONVERT;
                            r_row       <= r_row + 1'b1;
                            NRE         <= nre_for(r_row + 1'b1);
                            ADC         <= 1'b1;
                            r_ramp      <= '0;
`ifdef DIGITAL_CDS_EN
                            Erase       <= 1'b1;
                            r_cds_phase <= c_PH_RST;
`endif
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_readout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pixel_array_readout
// Brief    : Randomized self-checking bench with a timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_array_readout;

    localparam int ROWS         = 2;
    localparam int COLS         = 2;
    localparam int ADC_BITS     = 4;
    localparam int ERASE_CYCLES = 5;
    localparam int RW           = 1;
    localparam int RAMP         = 1 << ADC_BITS;
    localparam int MAXV         = RAMP - 1;
`ifdef DIGITAL_CDS_EN
    localparam int ADC_ROW = 2 * RAMP;
    localparam logic [COLS*ADC_BITS-1:0] ROW0_DATA = 8'h06;
`else
    localparam int ADC_ROW = RAMP;
    localparam logic [COLS*ADC_BITS-1:0] ROW0_DATA = 8'hB5;
`endif
    localparam logic [COLS*ADC_BITS-1:0] ROW1_DATA = 8'hF0;

    logic                     Clk = 1'b0;
    logic                     Reset;
    logic                     Init;
    logic [15:0]              Expose_time;
    logic [COLS-1:0]          Comp;
    logic                     Erase;
    logic                     Expose;
    logic [ROWS-1:0]          NRE;
    logic                     ADC;
    logic [COLS*ADC_BITS-1:0] Data;
    logic                     Data_valid;
    logic                     Data_ready;
    logic [RW-1:0]            Row_idx;
    logic                     Busy;
    logic                     Frame_done;

    pixel_array_readout #(
        .ROWS(ROWS), .COLS(COLS), .ADC_BITS(ADC_BITS), .ERASE_CYCLES(ERASE_CYCLES)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Expose_time(Expose_time),
        .Comp(Comp), .Erase(Erase), .Expose(Expose), .NRE(NRE), .ADC(ADC),
        .Data(Data), .Data_valid(Data_valid), .Data_ready(Data_ready),
        .Row_idx(Row_idx), .Busy(Busy), .Frame_done(Frame_done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- reference model: expected outputs per cycle ----------------
    int  thr_sig [ROWS][COLS];
    int  thr_rst [ROWS][COLS];
    int  ready_hold [ROWS];
    int  ready_pct = 100;
    bit  noise = 1'b0;
    bit  aborted = 1'b0;
    int  ramp_val [COLS];

    logic                     exp_erase, exp_expose, exp_adc, exp_dv, exp_busy, exp_fd;
    logic [ROWS-1:0]          exp_nre;
    logic [COLS*ADC_BITS-1:0] exp_data;
    logic [RW-1:0]            exp_row;

    function automatic logic [ROWS-1:0] nre_of(input int r);
        logic [ROWS-1:0] v;
        v    = '1;
        v[r] = 1'b0;
        return v;
    endfunction

    task automatic set_exp(input logic er, input logic ex, input logic [ROWS-1:0] nre,
                           input logic adc, input logic dv, input logic busy, input logic fd);
        exp_erase = er; exp_expose = ex; exp_nre = nre; exp_adc = adc;
        exp_dv = dv; exp_busy = busy; exp_fd = fd;
    endtask

    // Advance one clock; Comp and Data_ready default to noise outside ramps/output.
    task automatic tick();
        logic [31:0] rnd;
        @(posedge Clk);
        #1;
        if (!Reset) aborted = 1'b1;
        rnd        = $urandom;
        Comp       = rnd[COLS-1:0];
        Data_ready = rnd[COLS];
    endtask

    // One ramp: value per column = first cycle index with Comp high, else full scale.
    task automatic do_ramp(input int r, input bit rst_ph);
        int          first [COLS];
        int          t;
        logic [31:0] rnd;
        for (int c = 0; c < COLS; c++) first[c] = -1;
        for (int k = 0; k < RAMP; k++) begin
            set_exp(rst_ph, 1'b0, nre_of(r), 1'b1, 1'b0, 1'b1, 1'b0);
            rnd = $urandom;
            for (int c = 0; c < COLS; c++) begin
                t = rst_ph ? thr_rst[r][c] : thr_sig[r][c];
                Comp[c] = (k == t) || ((k > t) && (!noise || rnd[c]));
                if (Comp[c] && first[c] < 0) first[c] = k;
            end
            tick();
            if (aborted) return;
        end
        for (int c = 0; c < COLS; c++) ramp_val[c] = (first[c] < 0) ? MAXV : first[c];
    endtask

    task automatic run_frame(input int x);
        int  hold;
        bit  rdy;
        int  res [COLS];
`ifdef DIGITAL_CDS_EN
        int  rst_v [COLS];
`endif
        for (int i = 0; i < ERASE_CYCLES; i++) begin
            set_exp(1'b1, 1'b0, '1, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (aborted) return;
        end
        for (int i = 0; i < x; i++) begin
            set_exp(1'b0, 1'b1, '1, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (aborted) return;
        end
        for (int r = 0; r < ROWS; r++) begin
`ifdef DIGITAL_CDS_EN
            do_ramp(r, 1'b1);
            if (aborted) return;
            rst_v = ramp_val;
            set_exp(1'b0, 1'b0, nre_of(r), 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            if (aborted) return;
            do_ramp(r, 1'b0);
            if (aborted) return;
            for (int c = 0; c < COLS; c++)
                res[c] = (ramp_val[c] > rst_v[c]) ? ramp_val[c] - rst_v[c] : 0;
`else
            do_ramp(r, 1'b0);
            if (aborted) return;
            res = ramp_val;
`endif
            for (int c = 0; c < COLS; c++) exp_data[c*ADC_BITS +: ADC_BITS] = ADC_BITS'(res[c]);
            exp_row = RW'(r);
            hold    = ready_hold[r];
            rdy     = 1'b0;
            while (!rdy) begin
                set_exp(1'b0, 1'b0, '1, 1'b0, 1'b1, 1'b1, 1'b0);
                rdy = (hold > 0) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
                if (hold > 0) hold--;
                Data_ready = rdy;
                tick();
                if (aborted) return;
            end
        end
        set_exp(1'b0, 1'b0, '1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic reset_exp();
        set_exp(1'b0, 1'b0, '1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_data = '0;
        exp_row  = '0;
    endtask

    initial begin : model
        int x;
        Comp       = '0;
        Data_ready = 1'b0;
        reset_exp();
        forever begin
            tick();
            if (aborted) begin
                aborted = 1'b0;
                reset_exp();
            end else if (Init) begin
                x = (Expose_time == 16'd0) ? 1 : int'(Expose_time);
                run_frame(x);
                if (aborted) begin
                    aborted = 1'b0;
                    reset_exp();
                end else begin
                    set_exp(1'b0, 1'b0, '1, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("Erase",      64'(Erase),      64'(exp_erase));
            chk("Expose",     64'(Expose),     64'(exp_expose));
            chk("NRE",        64'(NRE),        64'(exp_nre));
            chk("ADC",        64'(ADC),        64'(exp_adc));
            chk("Data_valid", 64'(Data_valid), 64'(exp_dv));
            chk("Busy",       64'(Busy),       64'(exp_busy));
            chk("Frame_done", 64'(Frame_done), 64'(exp_fd));
            chk("Data",       64'(Data),       64'(exp_data));
            chk("Row_idx",    64'(Row_idx),    64'(exp_row));
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_frame(input logic [15:0] et);
        logic [31:0] rnd;
        @(posedge Clk); #3;
        Expose_time = et;
        Init        = 1'b1;
        @(posedge Clk); #3;
        Init        = 1'b0;
        rnd         = $urandom;
        Expose_time = rnd[15:0];
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n_er, n_ex, n_adc0, nre_bad, n_dv, n_fd;
        logic [COLS*ADC_BITS-1:0] d0, d1;
        logic [RW-1:0] r0, r1;
        bit done, seen, ended;
        logic [31:0] rnd;

        Reset = 1'b0; Init = 1'b0; Expose_time = '0;
        @(posedge Clk); #3;
        chk_en = 1'b1;
        @(negedge Clk);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_nre",  64'(NRE),  64'd3);
        @(posedge Clk); #3;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);

        // Directed frame with hand-computed results.
`ifdef DIGITAL_CDS_EN
        thr_rst[0][0] = 3;  thr_sig[0][0] = 9;
        thr_rst[0][1] = 9;  thr_sig[0][1] = 3;
`else
        thr_rst[0][0] = 0;  thr_sig[0][0] = 5;
        thr_rst[0][1] = 0;  thr_sig[0][1] = 11;
`endif
        thr_rst[1][0] = 0;  thr_sig[1][0] = 0;
        thr_rst[1][1] = 0;  thr_sig[1][1] = RAMP;
        ready_hold[0] = 0;  ready_hold[1] = 10;
        ready_pct = 100;
        noise = 1'b1;
        start_frame(16'd3);
        n_er = 0; n_ex = 0; n_adc0 = 0; nre_bad = 0; n_dv = 0; n_fd = 0;
        d0 = '0; d1 = '0; r0 = '0; r1 = '0; done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge Clk);
            if (Erase && !ADC) n_er++;
            if (Expose) n_ex++;
            if (ADC && n_dv == 0) begin
                n_adc0++;
                if (NRE !== 2'b10) nre_bad++;
            end
            if (Data_valid) begin
                if (n_dv == 0) begin d0 = Data; r0 = Row_idx; end
                d1 = Data; r1 = Row_idx;
                n_dv++;
            end
            if (Frame_done) n_fd++;
            if (!Busy && n_fd > 0) done = 1'b1;
        end
        chk("dir_frame_end",   64'(done),    64'd1);
        chk("dir_erase_len",   64'(n_er),    64'd5);
        chk("dir_expose_len",  64'(n_ex),    64'd3);
        chk("dir_adc_len",     64'(n_adc0),  64'(ADC_ROW));
        chk("dir_nre_row0",    64'(nre_bad), 64'd0);
        chk("dir_row0_data",   64'(d0),      64'(ROW0_DATA));
        chk("dir_row0_idx",    64'(r0),      64'd0);
        chk("dir_row1_data",   64'(d1),      64'(ROW1_DATA));
        chk("dir_row1_idx",    64'(r1),      64'd1);
        chk("dir_valid_cycles",64'(n_dv),    64'd12);
        chk("dir_frame_done",  64'(n_fd),    64'd1);

        // Reset in the middle of a conversion.
        ready_hold[1] = 0;
        ready_pct = 60;
        noise = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                thr_sig[r][c] = $urandom_range(0, RAMP + 2);
                thr_rst[r][c] = $urandom_range(0, RAMP + 2);
            end
        start_frame(16'd2);
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge Clk);
            if (ADC) seen = 1'b1;
        end
        chk("rst_adc_seen", 64'(seen), 64'd1);
        repeat (3) @(posedge Clk);
        #3 Reset = 1'b0;
        @(posedge Clk); #3 Reset = 1'b1;
        @(negedge Clk);
        chk("rst_mid_busy",  64'(Busy),       64'd0);
        chk("rst_mid_nre",   64'(NRE),        64'd3);
        chk("rst_mid_adc",   64'(ADC),        64'd0);
        chk("rst_mid_data",  64'(Data),       64'd0);
        chk("rst_mid_valid", 64'(Data_valid), 64'd0);
        repeat (2) @(posedge Clk);

        // Randomized frames with stray Init pulses while busy.
        for (int f = 0; f < 8; f++) begin
            noise = ($urandom_range(0, 1) == 1);
            ready_pct = $urandom_range(30, 100);
            for (int r = 0; r < ROWS; r++) begin
                ready_hold[r] = $urandom_range(0, 3);
                for (int c = 0; c < COLS; c++) begin
                    thr_sig[r][c] = $urandom_range(0, RAMP + 2);
                    thr_rst[r][c] = $urandom_range(0, RAMP + 2);
                end
            end
            start_frame(16'($urandom_range(0, 6)));
            ended = 1'b0;
            for (int cyc = 0; cyc < 800 && !ended; cyc++) begin
                @(posedge Clk); #3;
                if (!Busy) begin
                    ended = 1'b1;
                    Init  = 1'b0;
                end else begin
                    rnd         = $urandom;
                    Init        = (rnd[1:0] == 2'b00);
                    Expose_time = rnd[31:16];
                end
            end
            Init = 1'b0;
            chk("rand_frame_end", 64'(ended), 64'd1);
            repeat ($urandom_range(1, 4)) @(posedge Clk);
        end

        repeat (5) @(posedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_array_readout.md
Name: pixel_array_readout

Overview:
- Parametrised successor to the single-pixel control block.
- Sequences erase, expose and row-by-row ramp-compare conversion for an array of ROWS x COLS pixels with per-column digital counters.
- Presents one row of COLS results per ready/valid beat to the downstream frame buffer.
- Sits between the frame controller (Init, Expose_time) and the analog pixel array (Erase, Expose, NRE, ADC, Comp).

Parameters:
- ROWS, 2, number of pixel rows (one NRE line each)
- COLS, 2, number of columns (one comparator and counter each)
- ADC_BITS, 8, conversion resolution; ramp lasts 2^ADC_BITS cycles
- ERASE_CYCLES, 5, cycles Erase is held high

Ports:
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  synchronous reset, active-low
- Init  in  1  start-of-frame pulse; sampled only in IDLE
- Expose_time  in  16  exposure length in cycles; sampled on accepted Init
- Comp  in  COLS  per-column comparator; 1 = ramp has passed pixel level
- Erase  out  1  pixel reset to analog array
- Expose  out  1  exposure enable to analog array
- NRE  out  ROWS  active-low row read enables; at most one bit low
- ADC  out  1  ramp generator run enable
- Data  out  COLS*ADC_BITS  row result; column c at bits [c*ADC_BITS +: ADC_BITS]
- Data_valid  out  1  Data holds a valid row
- Data_ready  in  1  downstream accepts Data when Data_valid & Data_ready
- Row_idx  out  clog2(ROWS) (min 1)  row currently in Data
- Busy  out  1  high in every state except IDLE
- Frame_done  out  1  one-cycle pulse after the last row is accepted

Behaviour:
- Reset (Reset=0 at a Clk edge), from any state including mid-conversion:
  - State = IDLE; Erase=0, Expose=0, ADC=0, NRE=all 1s, Data=0, Data_valid=0, Row_idx=0, Busy=0, Frame_done=0.
  - Counters and latches cleared.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> OUTPUT -> (CONVERT for next row | DONE) -> IDLE.
- IDLE -> ERASE: on Init=1.
  - Busy rises the next cycle.
  - Expose_time is latched; a value of 0 is treated as 1.
  - Init in any other state is ignored.
- ERASE: Erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: Expose=1 for exactly the latched Expose_time cycles, then CONVERT with row=0. Erase and Expose are never high together.
- CONVERT (row r):
  - NRE[r]=0, ADC=1; ramp counter runs 0 .. 2^ADC_BITS-1, one count per cycle.
  - Column c latches the counter value in the first cycle Comp[c]=1; later changes on Comp[c] are ignored.
  - If Comp[c] is already 1 in the first convert cycle, the column latches 0.
  - A column that never sees Comp[c]=1 saturates to all ones.
  - After the final count: ADC=0, NRE=all 1s next cycle, go to OUTPUT.
  - Convert latency per row = 2^ADC_BITS cycles.
- OUTPUT:
  - Data_valid=1; Data and Row_idx=r held stable until Data_ready=1.
  - On handshake, Data_valid drops the next cycle.
  - If r < ROWS-1, go to CONVERT with r+1; else go to DONE.
  - Data_ready while Data_valid=0 has no effect.
- DONE: Frame_done=1 for one cycle, then IDLE. Init in the same cycle is ignored; a new frame needs Init in IDLE.
- Data retains the last row value until the next OUTPUT.

Optional Feature:
- Macro DIGITAL_CDS_EN.
- When defined, each row performs two conversions:
  - Reset sample: NRE[r]=0 and Erase=1 during the ramp.
  - Signal sample: NRE[r]=0, Erase=0.
  - Output per column = signal minus reset, clamped at 0.
  - Convert latency per row becomes 2*2^ADC_BITS + 1 cycles, including one idle cycle between ramps with ADC=0.
- When not defined: single signal conversion as above; no subtractor logic is synthesised.

Test Plan:
- Reset mid-CONVERT (ROWS=2, COLS=2, ADC_BITS=4): assert Reset=0 for 1 cycle -> next cycle all outputs at reset values, Busy=0, NRE=2'b11.
- Init with Expose_time=3 -> Erase high exactly 5 cycles, then Expose high exactly 3 cycles, then NRE=2'b10 and ADC=1 for 16 cycles.
- Row 0 Comp[0] rises at count 5, Comp[1] at count 11, Data_ready=1 -> Data={4'd11,4'd5}, Row_idx=0, Data_valid for 1 cycle; row 1 converts next.
- Comp[1] never rises and Comp[0] high from the first cycle -> column 1 = 4'hF, column 0 = 4'h0.
- Data_ready low for 10 cycles in OUTPUT -> Data_valid and Data stable for all 10; row 1 NRE stays high until the handshake.
- Last row accepted -> Frame_done pulses 1 cycle, then Busy=0. Init asserted while Busy=1 -> no restart.
- With DIGITAL_CDS_EN: reset sample 3, signal sample 9 -> output 6; reset 9, signal 3 -> output 0.
